// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered reads, write-to-read bypass,
// optional hardwired-zero R0 and a per-register pending-write scoreboard.
module regfile_2r1w #(
  parameter int W        = 16,
  parameter int AW       = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     ra1_i,
  input  logic [AW-1:0]     ra2_i,
  output logic [W-1:0]      rdata1_o,
  output logic [W-1:0]      rdata2_o,
  output logic              busy1_o,
  output logic              busy2_o,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [W-1:0]      wdata_i,
  input  logic              rsv_en_i,
  input  logic [AW-1:0]     rsv_addr_i,
  output logic [2**AW-1:0]  busy_vec_o
);

  localparam int DEPTH = 2**AW;

  logic [W-1:0]     regs_q [DEPTH];
  logic [W-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [W-1:0]     rdata1_q, rdata1_d;
  logic [W-1:0]     rdata2_q, rdata2_d;
  logic             busy1_q, busy1_d;
  logic             busy2_q, busy2_d;
  logic             wr_ok_s;
  logic             rsv_ok_s;

  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == {AW{1'b0}});
  endfunction

  // Bypass makes the data written on this edge visible to a read on the same edge.
  function automatic logic [W-1:0] read_data(input logic [AW-1:0] addr);
    if (is_zero_reg(addr)) begin
      return {W{1'b0}};
    end else if (wr_en_i && (wa_i == addr)) begin
      return wdata_i;
    end else begin
      return regs_q[addr];
    end
  endfunction

  assign wr_ok_s  = wr_en_i  && !is_zero_reg(wa_i);
  assign rsv_ok_s = rsv_en_i && !is_zero_reg(rsv_addr_i);

  // Next-state register array and scoreboard; a reserve after the clear lets the newer producer win.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok_s) begin
      regs_d[wa_i] = wdata_i;
      busy_d[wa_i] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (rsv_ok_s) begin
      busy_d[rsv_addr_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // Read port capture; busy flags come from the post-edge scoreboard.
  always_comb begin
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    busy1_d  = busy1_q;
    busy2_d  = busy2_q;
    if (rd_en_i) begin
      rdata1_d = read_data(ra1_i);
      rdata2_d = read_data(ra2_i);
      busy1_d  = busy_d[ra1_i];
      busy2_d  = busy_d[ra2_i];
    end else begin
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= {W{1'b0}};
      end
      busy_q   <= {DEPTH{1'b0}};
      rdata1_q <= {W{1'b0}};
      rdata2_q <= {W{1'b0}};
      busy1_q  <= 1'b0;
      busy2_q  <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      busy1_q  <= busy1_d;
      busy2_q  <= busy2_d;
    end
  end

  assign rdata1_o   = rdata1_q;
  assign rdata2_o   = rdata2_q;
  assign busy1_o    = busy1_q;
  assign busy2_o    = busy2_q;
  assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: one instance with a writable R0 and one with
// a hardwired-zero R0 share the same stimulus; expected values are hand-computed.
module tb_regfile_2r1w;

  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk_i;
  logic          rst_i;
  logic          rd_en_i;
  logic [AW-1:0] ra1_i, ra2_i;
  logic          wr_en_i;
  logic [AW-1:0] wa_i;
  logic [W-1:0]  wdata_i;
  logic          rsv_en_i;
  logic [AW-1:0] rsv_addr_i;

  logic [W-1:0]  rdata1_a, rdata2_a, rdata1_z, rdata2_z;
  logic          busy1_a, busy2_a, busy1_z, busy2_z;
  logic [7:0]    busy_vec_a, busy_vec_z;

  int checks = 0;
  int errors = 0;

  regfile_2r1w #(.W(W), .AW(AW), .ZERO_REG(0)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .rd_en_i(rd_en_i), .ra1_i(ra1_i), .ra2_i(ra2_i),
    .rdata1_o(rdata1_a), .rdata2_o(rdata2_a), .busy1_o(busy1_a), .busy2_o(busy2_a),
    .wr_en_i(wr_en_i), .wa_i(wa_i), .wdata_i(wdata_i), .rsv_en_i(rsv_en_i),
    .rsv_addr_i(rsv_addr_i), .busy_vec_o(busy_vec_a)
  );

  regfile_2r1w #(.W(W), .AW(AW), .ZERO_REG(1)) dut_z (
    .clk_i(clk_i), .rst_i(rst_i), .rd_en_i(rd_en_i), .ra1_i(ra1_i), .ra2_i(ra2_i),
    .rdata1_o(rdata1_z), .rdata2_o(rdata2_z), .busy1_o(busy1_z), .busy2_o(busy2_z),
    .wr_en_i(wr_en_i), .wa_i(wa_i), .wdata_i(wdata_i), .rsv_en_i(rsv_en_i),
    .rsv_addr_i(rsv_addr_i), .busy_vec_o(busy_vec_z)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic wr, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic rsv, input logic [AW-1:0] ra);
    rd_en_i = rd; ra1_i = a1; ra2_i = a2;
    wr_en_i = wr; wa_i = wa; wdata_i = wd;
    rsv_en_i = rsv; rsv_addr_i = ra;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd1a"}, {16'h0, rdata1_a}, 32'h0);
    check({tag, "_rd2a"}, {16'h0, rdata2_a}, 32'h0);
    check({tag, "_bsya"}, {30'h0, busy1_a, busy2_a}, 32'h0);
    check({tag, "_veca"}, {24'h0, busy_vec_a}, 32'h0);
    check({tag, "_rd1z"}, {16'h0, rdata1_z}, 32'h0);
    check({tag, "_vecz"}, {24'h0, busy_vec_z}, 32'h0);
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    #12;
    check_all_zero("reset");
    rst_i = 1'b0;

    // Write then read; unwritten register reads zero
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0); tick();
    check("no_rd_yet", {16'h0, rdata1_a}, 32'h0);
    drive(1'b1, 3'd5, 3'd3, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0); tick();
    check("rd5", {16'h0, rdata1_a}, 32'h0000BEEF);
    check("rd3_unwritten", {16'h0, rdata2_a}, 32'h0);
    check("rd5_z", {16'h0, rdata1_z}, 32'h0000BEEF);

    // Same-edge bypass on both ports
    drive(1'b1, 3'd2, 3'd2, 1'b1, 3'd2, 16'h1234, 1'b0, 3'd0); tick();
    check("byp1", {16'h0, rdata1_a}, 32'h00001234);
    check("byp2", {16'h0, rdata2_a}, 32'h00001234);
    check("byp2_z", {16'h0, rdata2_z}, 32'h00001234);

    // Reserve with read disabled: outputs hold
    drive(1'b0, 3'd4, 3'd4, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4); tick();
    check("rsv4_vec", {24'h0, busy_vec_a}, 32'h10);
    check("hold_rd1", {16'h0, rdata1_a}, 32'h00001234);
    check("hold_bsy1", {31'h0, busy1_a}, 32'h0);
    drive(1'b1, 3'd4, 3'd5, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0); tick();
    check("rsv4_busy1", {31'h0, busy1_a}, 32'h1);
    check("rsv4_busy2", {31'h0, busy2_a}, 32'h0);
    check("rd5_again", {16'h0, rdata2_a}, 32'h0000BEEF);

    // Write clears reservation
    drive(1'b0, 3'd4, 3'd5, 1'b1, 3'd4, 16'h0007, 1'b0, 3'd0); tick();
    check("wr4_vec", {24'h0, busy_vec_a}, 32'h0);
    check("wr4_hold_bsy", {31'h0, busy1_a}, 32'h1);
    drive(1'b1, 3'd4, 3'd2, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0); tick();
    check("rd4_busy", {31'h0, busy1_a}, 32'h0);
    check("rd4_data", {16'h0, rdata1_a}, 32'h00000007);
    check("rd2_data", {16'h0, rdata2_a}, 32'h00001234);

    // Busy flags see the same-edge reserve and clear
    drive(1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3); tick();
    check("rsv3_same_b1", {31'h0, busy1_a}, 32'h1);
    check("rsv3_same_b2", {31'h0, busy2_a}, 32'h1);
    check("rsv3_vec", {24'h0, busy_vec_a}, 32'h08);
    drive(1'b1, 3'd3, 3'd3, 1'b1, 3'd3, 16'h5A5A, 1'b0, 3'd0); tick();
    check("wr3_same_b1", {31'h0, busy1_a}, 32'h0);
    check("wr3_byp", {16'h0, rdata1_a}, 32'h00005A5A);
    check("wr3_vec", {24'h0, busy_vec_a}, 32'h0);

    // Reserve and write same register same edge: busy stays
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd6, 16'h00AA, 1'b1, 3'd6); tick();
    check("rw6_vec", {24'h0, busy_vec_a}, 32'h40);
    drive(1'b1, 3'd6, 3'd6, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0); tick();
    check("rw6_data", {16'h0, rdata1_a}, 32'h000000AA);
    check("rw6_busy", {31'h0, busy1_a}, 32'h1);

    // Register 0: writable in one instance, hardwired zero in the other
    drive(1'b1, 3'd0, 3'd6, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0); tick();
    check("z0_rd1", {16'h0, rdata1_z}, 32'h0);
    check("z0_busy1", {31'h0, busy1_z}, 32'h0);
    check("z0_vec", {24'h0, busy_vec_z}, 32'h40);
    check("r0_byp", {16'h0, rdata1_a}, 32'h0000FFFF);
    check("r0_busy1", {31'h0, busy1_a}, 32'h1);
    check("r0_vec", {24'h0, busy_vec_a}, 32'h41);
    drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0); tick();
    check("z0_reread", {16'h0, rdata1_z}, 32'h0);
    check("r0_reread", {16'h0, rdata1_a}, 32'h0000FFFF);

    // Fill and reserve, then reset mid-cycle
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 16'h1111, 1'b1, 3'd7); tick();
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 16'h7777, 1'b1, 3'd7); tick();
    drive(1'b1, 3'd1, 3'd7, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1); tick();
    check("pre_rd1", {16'h0, rdata1_a}, 32'h00001111);
    check("pre_rd2", {16'h0, rdata2_a}, 32'h00007777);
    check("pre_busy", {30'h0, busy1_a, busy2_a}, 32'h3);
    check("pre_vec_a", {24'h0, busy_vec_a}, 32'hC3);
    check("pre_vec_z", {24'h0, busy_vec_z}, 32'hC2);
    drive(1'b0, 3'd1, 3'd7, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    check_all_zero("held_rst");
    rst_i = 1'b0;
    tick();
    tick();
    check_all_zero("post_rst_hold");
    drive(1'b1, 3'd1, 3'd7, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0); tick();
    check_all_zero("post_rst_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
